regfile_sb: RTL and testbench

Parametrised general-purpose register file for the CPU datapath: one write port, two read ports and a per-register pending-write scoreboard. Generalises the fixed 32x32 file in width and depth and adds synchronous clear, optional hardwired-zero register 0, write-to-read bypass and busy tracking. Issue logic marks a destination busy via the reserve port; writeback clears it.

---
 rtl/regfile_sb.sv | 118 +++++++++++
 tb/tb_regfile_sb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Parametrised register file: one write port, two registered read ports and a
// per-register pending-write scoreboard with optional zero register and bypass.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_en1,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic              read_en2,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1_o,
  output logic [DATA_W-1:0] read_data2_o,
  output logic              read_busy1_o,
  output logic              read_busy2_o,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_reg
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic [DEPTH-1:0]  busy_nxt_s;
  logic              wr_ok_s;
  logic              rsv_ok_s;
  logic [DATA_W-1:0] rd1_data_s;
  logic [DATA_W-1:0] rd2_data_s;
  logic              rd1_busy_s;
  logic              rd2_busy_s;

  function automatic logic is_zero_idx(input logic [ADDR_W-1:0] idx);
    return (ZERO_REG != 0) && (idx == {ADDR_W{1'b0}});
  endfunction

  // Returns {busy, data} seen by a read port, applying zero-register and bypass priority.
  function automatic logic [DATA_W:0] read_sel(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] stored,
    input logic              busy_bit,
    input logic              we,
    input logic [ADDR_W-1:0] wr,
    input logic [DATA_W-1:0] wd
  );
    if (is_zero_idx(idx)) begin
      return {1'b0, {DATA_W{1'b0}}};
    end else if ((BYPASS != 0) && we && (wr == idx)) begin
      return {1'b0, wd};
    end else begin
      return {busy_bit, stored};
    end
  endfunction

  // Qualify write/reserve and build next scoreboard; reserve wins over a same-index write.
  always_comb begin
    wr_ok_s    = write_en && !is_zero_idx(write_reg);
    rsv_ok_s   = rsv_en && !is_zero_idx(rsv_reg);
    busy_nxt_s = busy_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (rsv_ok_s && (rsv_reg == ADDR_W'(i))) begin
        busy_nxt_s[i] = 1'b1;
      end else if (wr_ok_s && (write_reg == ADDR_W'(i))) begin
        busy_nxt_s[i] = 1'b0;
      end else begin
        busy_nxt_s[i] = busy_r[i];
      end
    end
  end

  // Read-port selection against pre-edge storage.
  always_comb begin
    {rd1_busy_s, rd1_data_s} = read_sel(read_reg1, mem_r[read_reg1], busy_r[read_reg1],
                                        write_en, write_reg, write_data);
    {rd2_busy_s, rd2_data_s} = read_sel(read_reg2, mem_r[read_reg2], busy_r[read_reg2],
                                        write_en, write_reg, write_data);
  end

  // Register storage and scoreboard.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
      busy_r <= {DEPTH{1'b0}};
    end else begin
      if (wr_ok_s) begin
        mem_r[write_reg] <= write_data;
      end
      busy_r <= busy_nxt_s;
    end
  end

  // Registered read outputs; a disabled port holds its last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_data1_o <= {DATA_W{1'b0}};
      read_data2_o <= {DATA_W{1'b0}};
      read_busy1_o <= 1'b0;
      read_busy2_o <= 1'b0;
    end else begin
      if (read_en1) begin
        read_data1_o <= rd1_data_s;
        read_busy1_o <= rd1_busy_s;
      end
      if (read_en2) begin
        read_data2_o <= rd2_data_s;
        read_busy2_o <= rd2_busy_s;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a default instance (32x32, zero reg, bypass)
// and a small instance (16x8, no zero reg, no bypass) against a behavioural model.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic        a_we, a_re1, a_re2, a_rsv;
  logic [4:0]  a_wr, a_r1, a_r2, a_rr;
  logic [31:0] a_wd, a_d1, a_d2;
  logic        a_b1, a_b2;
  // Instance B: DATA_W=16, ADDR_W=3, ZERO_REG=0, BYPASS=0
  logic        b_we, b_re1, b_re2, b_rsv;
  logic [2:0]  b_wr, b_r1, b_r2, b_rr;
  logic [15:0] b_wd, b_d1, b_d2;
  logic        b_b1, b_b2;

  regfile_sb dut_a (
    .clk(clk), .rst_n(rst_n),
    .write_en(a_we), .write_reg(a_wr), .write_data(a_wd),
    .read_en1(a_re1), .read_reg1(a_r1), .read_en2(a_re2), .read_reg2(a_r2),
    .read_data1_o(a_d1), .read_data2_o(a_d2), .read_busy1_o(a_b1), .read_busy2_o(a_b2),
    .rsv_en(a_rsv), .rsv_reg(a_rr)
  );

  regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .write_en(b_we), .write_reg(b_wr), .write_data(b_wd),
    .read_en1(b_re1), .read_reg1(b_r1), .read_en2(b_re2), .read_reg2(b_r2),
    .read_data1_o(b_d1), .read_data2_o(b_d2), .read_busy1_o(b_b1), .read_busy2_o(b_b2),
    .rsv_en(b_rsv), .rsv_reg(b_rr)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: index 0 = instance A, 1 = instance B
  logic [31:0] m_mem  [2][32];
  logic        m_busy [2][32];
  logic [31:0] e_d1 [2];
  logic [31:0] e_d2 [2];
  logic        e_b1 [2];
  logic        e_b2 [2];

  task automatic model_step(input int u, input bit zr, input bit byp, input bit rst,
                            input bit we, input logic [4:0] wr, input logic [31:0] wd,
                            input bit re1, input logic [4:0] r1,
                            input bit re2, input logic [4:0] r2,
                            input bit rsv, input logic [4:0] rr);
    logic [31:0] d;
    logic        b;
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[u][i]  = 32'h0;
        m_busy[u][i] = 1'b0;
      end
      e_d1[u] = 32'h0; e_d2[u] = 32'h0; e_b1[u] = 1'b0; e_b2[u] = 1'b0;
    end else begin
      if (re1) begin
        if (zr && r1 == 5'd0) begin d = 32'h0; b = 1'b0; end
        else if (byp && we && wr == r1) begin d = wd; b = 1'b0; end
        else begin d = m_mem[u][r1]; b = m_busy[u][r1]; end
        e_d1[u] = d; e_b1[u] = b;
      end
      if (re2) begin
        if (zr && r2 == 5'd0) begin d = 32'h0; b = 1'b0; end
        else if (byp && we && wr == r2) begin d = wd; b = 1'b0; end
        else begin d = m_mem[u][r2]; b = m_busy[u][r2]; end
        e_d2[u] = d; e_b2[u] = b;
      end
      if (we && !(zr && wr == 5'd0)) begin
        m_mem[u][wr]  = wd;
        m_busy[u][wr] = 1'b0;
      end
      if (rsv && !(zr && rr == 5'd0)) m_busy[u][rr] = 1'b1;
    end
  endtask

  task automatic idle();
    a_we = 1'b0; a_re1 = 1'b0; a_re2 = 1'b0; a_rsv = 1'b0;
    a_wr = 5'd0; a_r1 = 5'd0; a_r2 = 5'd0; a_rr = 5'd0; a_wd = 32'h0;
    b_we = 1'b0; b_re1 = 1'b0; b_re2 = 1'b0; b_rsv = 1'b0;
    b_wr = 3'd0; b_r1 = 3'd0; b_r2 = 3'd0; b_rr = 3'd0; b_wd = 16'h0;
  endtask

  // One clock: advance the model on current inputs, then sample 1 time unit after the edge
  task automatic step();
    model_step(0, 1'b1, 1'b1, rst_n, a_we, a_wr, a_wd, a_re1, a_r1, a_re2, a_r2, a_rsv, a_rr);
    model_step(1, 1'b0, 1'b0, rst_n, b_we, {2'b00, b_wr}, {16'h0, b_wd},
               b_re1, {2'b00, b_r1}, b_re2, {2'b00, b_r2}, b_rsv, {2'b00, b_rr});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); step(); step();
    checks++; if ({a_d1, a_d2, a_b1, a_b2} !== 66'h0) begin failures++;
      $display("FAIL reset_a_outputs got=%h exp=0", {a_d1, a_d2, a_b1, a_b2}); end
    checks++; if ({b_d1, b_d2, b_b1, b_b2} !== 34'h0) begin failures++;
      $display("FAIL reset_b_outputs got=%h exp=0", {b_d1, b_d2, b_b1, b_b2}); end
    rst_n = 1'b1;
    a_we = 1'b1; a_wr = 5'd5; a_wd = 32'hDEADBEEF; a_rsv = 1'b1; a_rr = 5'd6; step(); idle();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    a_re1 = 1'b1; a_r1 = 5'd5; a_re2 = 1'b1; a_r2 = 5'd6; step(); idle();
    checks++; if (a_d1 !== 32'h0 || a_b1 !== 1'b0) begin failures++;
      $display("FAIL reset_r5 got=%h/%b exp=0/0", a_d1, a_b1); end
    checks++; if (a_b2 !== 1'b0) begin failures++;
      $display("FAIL reset_busy_r6 got=%b exp=0", a_b2); end
  endtask

  task automatic test_write_read();
    a_we = 1'b1; a_wr = 5'd7; a_wd = 32'h12345678; step(); idle();
    a_re1 = 1'b1; a_r1 = 5'd7; step(); idle();
    checks++; if (a_d1 !== 32'h12345678) begin failures++;
      $display("FAIL write_read got=%h exp=12345678", a_d1); end
    a_we = 1'b1; a_wr = 5'd7; a_wd = 32'h1; a_r1 = 5'd7; step(); idle();
    checks++; if (a_d1 !== 32'h12345678) begin failures++;
      $display("FAIL read_hold got=%h exp=12345678", a_d1); end
  endtask

  task automatic test_bypass_zero();
    a_we = 1'b1; a_wr = 5'd3; a_wd = 32'hA5A5A5A5; a_rsv = 1'b1; a_rr = 5'd3; step(); idle();
    a_we = 1'b1; a_wr = 5'd3; a_wd = 32'hA5A5A5A5;
    a_re1 = 1'b1; a_r1 = 5'd3; a_re2 = 1'b1; a_r2 = 5'd0; step(); idle();
    checks++; if (a_d1 !== 32'hA5A5A5A5 || a_b1 !== 1'b0) begin failures++;
      $display("FAIL bypass_p1 got=%h/%b exp=a5a5a5a5/0", a_d1, a_b1); end
    checks++; if (a_d2 !== 32'h0) begin failures++;
      $display("FAIL zero_p2 got=%h exp=0", a_d2); end
    a_we = 1'b1; a_wr = 5'd0; a_wd = 32'hFFFFFFFF; a_rsv = 1'b1; a_rr = 5'd0; step(); idle();
    a_re1 = 1'b1; a_r1 = 5'd0; step(); idle();
    checks++; if (a_d1 !== 32'h0 || a_b1 !== 1'b0) begin failures++;
      $display("FAIL zero_write got=%h/%b exp=0/0", a_d1, a_b1); end
  endtask

  task automatic test_scoreboard();
    a_rsv = 1'b1; a_rr = 5'd9; step(); idle();
    a_re1 = 1'b1; a_r1 = 5'd9; a_rsv = 1'b1; a_rr = 5'd10; step(); idle();
    checks++; if (a_b1 !== 1'b1) begin failures++;
      $display("FAIL rsv_busy got=%b exp=1", a_b1); end
    a_re2 = 1'b1; a_r2 = 5'd10; step(); idle();
    checks++; if (a_b2 !== 1'b1) begin failures++;
      $display("FAIL rsv_visible_next got=%b exp=1", a_b2); end
    a_rsv = 1'b1; a_rr = 5'd9; a_we = 1'b1; a_wr = 5'd9; a_wd = 32'h55; step(); idle();
    a_re1 = 1'b1; a_r1 = 5'd9; step(); idle();
    checks++; if (a_d1 !== 32'h55 || a_b1 !== 1'b1) begin failures++;
      $display("FAIL rsv_wins got=%h/%b exp=55/1", a_d1, a_b1); end
    a_we = 1'b1; a_wr = 5'd9; a_wd = 32'h66; step(); idle();
    a_re1 = 1'b1; a_r1 = 5'd9; step(); idle();
    checks++; if (a_d1 !== 32'h66 || a_b1 !== 1'b0) begin failures++;
      $display("FAIL wb_clears got=%h/%b exp=66/0", a_d1, a_b1); end
  endtask

  task automatic test_param();
    b_rsv = 1'b1; b_rr = 3'd0; step(); idle();
    b_we = 1'b1; b_wr = 3'd0; b_wd = 16'hBEEF; b_re1 = 1'b1; b_r1 = 3'd0; step(); idle();
    checks++; if (b_d1 !== 16'h0 || b_b1 !== 1'b1) begin failures++;
      $display("FAIL nobypass_old got=%h/%b exp=0/1", b_d1, b_b1); end
    b_re1 = 1'b1; b_r1 = 3'd0; step(); idle();
    checks++; if (b_d1 !== 16'hBEEF || b_b1 !== 1'b0) begin failures++;
      $display("FAIL r0_writable got=%h/%b exp=beef/0", b_d1, b_b1); end
    b_we = 1'b1; b_wr = 3'd7; b_wd = 16'h1234; step(); idle();
    b_re2 = 1'b1; b_r2 = 3'd7; step(); idle();
    checks++; if (b_d2 !== 16'h1234) begin failures++;
      $display("FAIL top_index got=%h exp=1234", b_d2); end
  endtask

  task automatic test_reset_mid();
    a_we = 1'b1; a_wr = 5'd4; a_wd = 32'h77; a_rsv = 1'b1; a_rr = 5'd4; step(); idle();
    rst_n = 1'b0; a_we = 1'b1; a_wr = 5'd4; a_wd = 32'h99; a_rsv = 1'b1; a_rr = 5'd4;
    a_re1 = 1'b1; a_r1 = 5'd4; step(); idle(); rst_n = 1'b1;
    a_re1 = 1'b1; a_r1 = 5'd4; step(); idle();
    checks++; if (a_d1 !== 32'h0 || a_b1 !== 1'b0) begin failures++;
      $display("FAIL reset_mid got=%h/%b exp=0/0", a_d1, a_b1); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      a_we = 1'($urandom); a_wr = 5'($urandom_range(0, 7)); a_wd = $urandom;
      a_re1 = 1'($urandom); a_r1 = 5'($urandom_range(0, 7));
      a_re2 = 1'($urandom); a_r2 = 5'($urandom_range(0, 7));
      a_rsv = 1'($urandom); a_rr = 5'($urandom_range(0, 7));
      b_we = 1'($urandom); b_wr = 3'($urandom); b_wd = 16'($urandom);
      b_re1 = 1'($urandom); b_r1 = 3'($urandom);
      b_re2 = 1'($urandom); b_r2 = 3'($urandom);
      b_rsv = 1'($urandom); b_rr = 3'($urandom);
      step();
      checks++; if (a_d1 !== e_d1[0] || a_b1 !== e_b1[0]) begin failures++;
        $display("FAIL rand_a_p1 n=%0d got=%h/%b exp=%h/%b", n, a_d1, a_b1, e_d1[0], e_b1[0]); end
      checks++; if (a_d2 !== e_d2[0] || a_b2 !== e_b2[0]) begin failures++;
        $display("FAIL rand_a_p2 n=%0d got=%h/%b exp=%h/%b", n, a_d2, a_b2, e_d2[0], e_b2[0]); end
      checks++; if (b_d1 !== e_d1[1][15:0] || b_b1 !== e_b1[1]) begin failures++;
        $display("FAIL rand_b_p1 n=%0d got=%h/%b exp=%h/%b", n, b_d1, b_b1, e_d1[1][15:0], e_b1[1]); end
      checks++; if (b_d2 !== e_d2[1][15:0] || b_b2 !== e_b2[1]) begin failures++;
        $display("FAIL rand_b_p2 n=%0d got=%h/%b exp=%h/%b", n, b_d2, b_b2, e_d2[1][15:0], e_b2[1]); end
    end
    rst_n = 1'b1; idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass_zero();
    test_scoreboard();
    test_param();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
